// File: rtl/npc_pkg.sv
// rtl/npc_pkg.sv - shared NPC constants and the write-back queue entry type.
package npc_pkg;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;

  typedef struct packed {
    logic             valid;
    logic             done;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  data;
  } wb_entry_t;

endpackage

// File: rtl/wb_lookup.sv
// rtl/wb_lookup.sv - youngest-match search of the write-back queue for one source register.
// WB_QUEUE_FWD_EN selects youngest-entry busy/forwarding; otherwise any match is busy.
module wb_lookup
  import npc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  wb_entry_t [DEPTH-1:0] entries,
  input  logic [AW-1:0]         head,
  input  logic [REG_W-1:0]      raddr,
  output logic                  busy,
  output logic [XLEN-1:0]       fwd_data
);

  logic            hit;
  logic            hit_done;
  logic [XLEN-1:0] hit_data;
  logic [AW-1:0]   idx;

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    hit      = 1'b0;
    hit_done = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + AW'(i);
      if (entries[idx].valid && (entries[idx].rd == raddr)) begin
        hit      = 1'b1;
        hit_done = entries[idx].done;
        hit_data = entries[idx].data;
      end
    end
  end

`ifdef WB_QUEUE_FWD_EN
  assign busy     = (raddr != '0) && hit && !hit_done;
  assign fwd_data = ((raddr != '0) && hit && hit_done) ? hit_data : '0;
`else
  assign busy     = (raddr != '0) && hit;
  assign fwd_data = '0;
`endif

endmodule

// File: rtl/wb_queue.sv
// rtl/wb_queue.sv - in-order write-back queue in front of the GPR file write port.
// Optional WB_QUEUE_FWD_EN: done results of the youngest matching entry are forwarded to decode.
module wb_queue
  import npc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = npc_pkg::XLEN,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_valid,
  output logic             alloc_ready,
  input  logic [4:0]       alloc_rd,
  input  logic             alloc_done,
  input  logic [XLEN-1:0]  alloc_data,
  output logic [AW-1:0]    alloc_tag,
  input  logic             ld_valid,
  input  logic [AW-1:0]    ld_tag,
  input  logic [XLEN-1:0]  ld_data,
  output logic             rf_wen,
  output logic [4:0]       rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  input  logic [4:0]       raddr1,
  input  logic [4:0]       raddr2,
  output logic             busy1,
  output logic             busy2,
  output logic [XLEN-1:0]  fwd1_data,
  output logic [XLEN-1:0]  fwd2_data,
  output logic             empty
);

  wb_entry_t [DEPTH-1:0] entries_q, entries_d;
  logic [AW-1:0]         head_q, head_d;
  logic [AW-1:0]         tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;

  logic      alloc_fire;
  logic      retire;
  wb_entry_t head_entry;

  assign head_entry  = entries_q[head_q];
  assign retire      = head_entry.valid && head_entry.done;
  assign alloc_ready = (count_q < CW'(DEPTH));
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign alloc_tag   = tail_q;
  assign empty       = (count_q == '0);

  assign rf_wen   = retire && (head_entry.rd != '0);
  assign rf_waddr = retire ? head_entry.rd : '0;
  assign rf_wdata = retire ? head_entry.data : '0;

  // A completion landing on the head only sets done; retire sees it next cycle.
  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q + CW'(alloc_fire) - CW'(retire);
    if (retire) begin
      entries_d[head_q].valid = 1'b0;
      head_d                  = head_q + AW'(1);
    end
    if (ld_valid && entries_q[ld_tag].valid && !entries_q[ld_tag].done) begin
      entries_d[ld_tag].done = 1'b1;
      entries_d[ld_tag].data = ld_data;
    end
    if (alloc_fire) begin
      entries_d[tail_q] = '{valid: 1'b1, done: alloc_done, rd: alloc_rd, data: alloc_data};
      tail_d            = tail_q + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entries_q <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

  wb_lookup #(.DEPTH(DEPTH)) u_lookup1 (
    .entries  (entries_q),
    .head     (head_q),
    .raddr    (raddr1),
    .busy     (busy1),
    .fwd_data (fwd1_data)
  );

  wb_lookup #(.DEPTH(DEPTH)) u_lookup2 (
    .entries  (entries_q),
    .head     (head_q),
    .raddr    (raddr2),
    .busy     (busy2),
    .fwd_data (fwd2_data)
  );

endmodule
